// File: rtl/imem_responder.sv
// Instruction-memory responder: single-cycle word fetch port plus a sequential
// bootloader program-load port that stalls fetch while a load is running.
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    input  logic [31:0]                    req_addr,
    output logic                           req_ready,
    output logic                           rsp_valid,
    output logic [31:0]                    rsp_instr,
    output logic                           rsp_err,
    input  logic                           load_start,
    input  logic                           load_valid,
    input  logic [31:0]                    load_data,
    input  logic                           load_end,
    output logic                           busy,
    output logic                           load_ovf,
    output logic [$clog2(DEPTH_WORDS):0]   load_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = IDX_W + 1;

    localparam logic [0:0] ST_SERVE = 1'b0;
    localparam logic [0:0] ST_LOAD  = 1'b1;

    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [29:0]      DEPTH_WORD = 30'(DEPTH_WORDS);

    logic [31:0]      mem_q [DEPTH_WORDS];

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] load_count_q, load_count_d;
    logic             load_ovf_q, load_ovf_d;
    logic             mem_we_s;

    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_instr_q, rsp_instr_d;
    logic             rsp_err_q, rsp_err_d;

    logic             req_ready_s;
    logic             req_fire_s;
    logic [31:0]      offset_s;
    logic             addr_err_s;
    logic [IDX_W-1:0] rd_idx_s;

    assign req_ready_s = (state_q == ST_SERVE) & ~load_start;
    assign req_fire_s  = req_valid & req_ready_s;

    // Subtraction wraps for addresses below BASE_ADDR, landing out of range.
    assign offset_s   = req_addr - BASE_ADDR;
    assign addr_err_s = (offset_s[1:0] != 2'b00) | (offset_s[31:2] >= DEPTH_WORD);
    assign rd_idx_s   = offset_s[IDX_W+1:2];

    // Load FSM next state; load pointer doubles as load_count and never wraps.
    always_comb begin
        state_d      = state_q;
        load_count_d = load_count_q;
        load_ovf_d   = load_ovf_q;
        mem_we_s     = 1'b0;
        case (state_q)
            ST_SERVE: begin
                if (load_start) begin
                    state_d      = ST_LOAD;
                    load_count_d = '0;
                    load_ovf_d   = 1'b0;
                end else begin
                    state_d = ST_SERVE;
                end
            end
            ST_LOAD: begin
                if (load_start) begin
                    state_d      = ST_LOAD;
                    load_count_d = '0;
                end else begin
                    if (load_valid) begin
                        if (load_count_q < DEPTH_CNT) begin
                            mem_we_s     = 1'b1;
                            load_count_d = load_count_q + CNT_ONE;
                        end else begin
                            load_ovf_d = 1'b1;
                        end
                    end else begin
                        load_ovf_d = load_ovf_q;
                    end
                    if (load_end) begin
                        state_d = ST_SERVE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            default: begin
                state_d      = ST_SERVE;
                load_count_d = '0;
            end
        endcase
    end

    // Response next state: outputs hold their last value when idle.
    always_comb begin
        rsp_valid_d = req_fire_s;
        rsp_instr_d = rsp_instr_q;
        rsp_err_d   = rsp_err_q;
        if (req_fire_s) begin
            if (addr_err_s) begin
                rsp_instr_d = NOP_INSTR;
                rsp_err_d   = 1'b1;
            end else begin
                rsp_instr_d = mem_q[rd_idx_s];
                rsp_err_d   = 1'b0;
            end
        end else begin
            rsp_err_d = rsp_err_q;
        end
    end

    // Control and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_SERVE;
            load_count_q <= '0;
            load_ovf_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_instr_q  <= NOP_INSTR;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_count_q <= load_count_d;
            load_ovf_q   <= load_ovf_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_instr_q  <= rsp_instr_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Instruction store; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s && !rst) begin
            mem_q[load_count_q[IDX_W-1:0]] <= load_data;
        end
    end

    assign req_ready  = req_ready_s;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_instr  = rsp_instr_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q == ST_LOAD);
    assign load_ovf   = load_ovf_q;
    assign load_count = load_count_q;

endmodule

// File: doc/imem_responder.md
# imem_responder

Responder end of the instruction-fetch interface: holds the instruction store, accepts one word-fetch request per cycle from the fetch stage and returns the instruction one cycle later. It also provides a sequential program-load port driven by the bootloader. While a load is in progress, fetch is stalled. Misaligned or out-of-range fetches return an error flag and a NOP.

## Interface
Parameters:
- DEPTH_WORDS, 4096: number of 32-bit instruction words stored; power of two, ≥ 4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; word-aligned.
- NOP_INSTR, 32'h0000_0013: value returned on error and after reset (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  fetch request present this cycle.
- req_addr  in  32  byte address of the requested instruction.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- rsp_valid  out  1  rsp_instr/rsp_err valid this cycle.
- rsp_instr  out  32  fetched instruction, or NOP_INSTR on error.
- rsp_err  out  1  response is for a misaligned or out-of-range address.
- load_start  in  1  single-cycle pulse that begins a program load at word 0.
- load_valid  in  1  load_data is to be written this cycle (LOAD state only).
- load_data  in  32  instruction word to be written.
- load_end  in  1  single-cycle pulse that ends the load.
- busy  out  1  high while in the LOAD state.
- load_ovf  out  1  sticky flag: a load write was dropped because the store was full.
- load_count  out  log2(DEPTH_WORDS)+1  number of words written in the current or most recent load.

## Operation
- Two-state FSM with states SERVE and LOAD. Reset enters SERVE.
- SERVE → LOAD on load_start. On entry, load pointer and load_count clear to 0 and load_ovf clears.
- LOAD → SERVE on load_end. load_start while in LOAD restarts: pointer and count clear to 0, and the state stays LOAD.
- load_end and load_valid in the same cycle: the write is performed, then the FSM exits to SERVE.
- LOAD write: when load_valid=1 and pointer < DEPTH_WORDS, write load_data to mem[pointer], then increment pointer and load_count. When pointer = DEPTH_WORDS, drop the write and set load_ovf. The pointer does not wrap.
- req_ready = (state==SERVE) & ~load_start. A load_start in the same cycle as a request wins, and the request is not accepted.
- Accepted request: compute offset = req_addr − BASE_ADDR using 32-bit unsigned arithmetic.
  - Error if req_addr[1:0] ≠ 0, or if offset[31:2] ≥ DEPTH_WORDS. This includes req_addr < BASE_ADDR, where the subtraction wraps to a large value.
  - No error: rsp_instr = mem[offset[31:2]] and rsp_err = 0.
  - Error: rsp_instr = NOP_INSTR and rsp_err = 1. No memory side effects.
- Memory contents are not cleared by reset. Reset mid-load aborts the load: state goes to SERVE, pointer and load_count go to 0, and words already written are retained.
- Reading a word never written since power-up returns an undefined value, and the bench must not check it.

## Timing
- Reset values: rsp_valid=0, rsp_instr=NOP_INSTR, rsp_err=0, busy=0, load_ovf=0, load_count=0, req_ready=1 (when load_start=0).
- Fetch latency is exactly 1 cycle. A request accepted at edge N yields rsp_valid=1 with its data during cycle N+1.
  - Back-to-back requests give one response per cycle, in order, with no bubbles.
  - When no request is accepted, rsp_valid=0 next cycle, while rsp_instr and rsp_err hold their last values.
- Response registers are registered outputs; no combinational path from req_* to rsp_*. req_ready is combinational from state and load_start.
- busy rises the cycle after load_start and falls the cycle after load_end.
- A word written at edge N is readable by a request accepted at or after the first SERVE cycle; there is no read/write overlap.
- load_count updates on the same edge as the write.
- A response already in flight when load_start arrives is still delivered in the following cycle.

## Test plan
- Reset, then load 4 words 0x00500093, 0x00A00113, 0x002081B3, 0x0000006F with load_end on the last word → busy=0, load_count=4, load_ovf=0. Fetch 0x0,0x4,0x8,0xC back-to-back → 4 consecutive rsp_valid cycles with the same words in order, rsp_err=0.
- Fetch 0x2 and 0x4000 with DEPTH_WORDS=4096 → rsp_instr=0x00000013, rsp_err=1. A following fetch of 0x4 returns 0x00A00113 with rsp_err=0.
- BASE_ADDR=0x1000: fetch 0x0FFC → rsp_err=1. Fetch 0x1000 → word 0.
- load_start asserted with req_valid=1 → req_ready=0 that cycle and no response next cycle. Load 4096 words plus 2 extra → load_ovf=1, load_count=4096, and mem[0] is not overwritten.
- Assert rst after 2 load writes → busy=0, load_count=0, all outputs at reset values. A fetch of 0x4 returns the second word written.
- load_valid and load_end in the same cycle with data 0xDEADBEEF → the word is stored, busy falls next cycle, and a later fetch returns 0xDEADBEEF.
